hf_decoder: RTL and testbench
=============================

// Module: hf_decoder
// PURPOSE
//  Serial Huffman decoder for the 5-symbol HF encoder's code table; the receive-side counterpart of HF.
//  Loads a packed code table plus code lengths, then consumes a bitstream one bit per cycle (valid/ready).
//  Emits the decoded 3-bit symbol index on a valid/ready output; flags streams that match no code.
// PARAMETERS
//  NSYM  5  number of symbols
//  CW    4  max code length / table field width (bits)
//  LW    3  code-length field width
//  SW    3  symbol index width
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         synchronous, active-high reset
//  tbl_load    in   1         capture code_table/code_len this cycle
//  code_table  in   NSYM*CW   HF packing: sym0 in [19:16] ... sym4 in [3:0]; code right-justified in field
//  code_len    in   NSYM*LW   sym0 in [14:12] ... sym4 in [2:0]; legal 1..CW
//  bit_in      in   1         stream bit, code MSB first
//  bit_valid   in   1         bit_in valid
//  bit_ready   out  1         decoder accepts bit_in this cycle
//  sym_out     out  SW        decoded symbol index 0..NSYM-1
//  sym_valid   out  1         sym_out valid; held until sym_ready
//  sym_ready   in   1         downstream accepts sym_out
//  err         out  1         sticky: no code matched in CW bits, or illegal length loaded
//  busy        out  1         partial code held (cnt != 0)
// BEHAVIOUR
//  Reset: state=IDLE; acc=0, cnt=0; bit_ready=0, sym_out=0, sym_valid=0, err=0, busy=0.
//  FSM: IDLE (no table) -> RUN on tbl_load. RUN -> ERR on mismatch after CW bits. ERR -> RUN only via tbl_load.
//  tbl_load (any state, priority over bit accept): registers table; clears acc/cnt/sym_valid/err.
//   Any code_len of 0 or >CW: err=1, state=ERR. Otherwise state=RUN.
//  bit_ready = (state==RUN) && (!sym_valid || sym_ready); combinational.
//  Bit accept (bit_valid && bit_ready): acc_n={acc[CW-2:0],bit_in}, cnt_n=cnt+1.
//   Match = any i with len[i]==cnt_n and code[i][cnt_n-1:0]==acc_n[cnt_n-1:0].
//   Match: next cycle sym_out=i, sym_valid=1, acc=0, cnt=0. Latency: 1 clk after the final bit is accepted.
//   Multiple matches (bad table): lowest index wins.
//   No match and cnt_n<CW: keep acc_n/cnt_n, busy=1.
//   No match and cnt_n==CW: err=1, state=ERR, acc/cnt cleared, sym_valid unchanged.
//  Output handshake: sym_valid && sym_ready clears sym_valid unless a new match lands that same cycle.
//   A new match in that cycle replaces sym_out and keeps sym_valid=1, giving back-to-back 1-bit codes at full rate.
//  sym_out holds its last value while sym_valid=0.
//  rst mid-code: partial acc discarded; table invalidated; back to IDLE.
//  Counters are width-exact; cnt never exceeds CW.
// TESTING
//  Table T: code_table=20'h01267, code_len=15'h22E4
//   (s0=00/2, s1=1/1, s2=010/3, s3=0110/4, s4=0111/4).
//  1) Load T, sym_ready=1, stream 1,0,0,0,1,0,0,1,1,1 -> sym 1,0,2,4, each valid 1 clk after its last bit; err=0.
//  2) Load T, send 1,1,1 with sym_ready=0 -> first sym=1 held, bit_ready=0, bits 2-3 not taken.
//     Raise sym_ready -> bits resume, emitting 1,1.
//  3) Load T with s4 code=4'b0110 (dup). Send 0110 -> sym 3 (lowest index).
//     Send 0111 -> err=1, bit_ready=0 until the next tbl_load, which clears err.
//  4) Load with s2 len=0 -> err=1, state ERR, bit_ready=0. Reload T -> err=0, bit_ready=1.
//  5) Load T, send 0,1 (busy=1), assert rst -> all outputs 0, bit_ready=0 until tbl_load.
//     After reload, 0110 -> sym 3.
//  6) tbl_load while sym_valid=1 and bit_valid=1 -> sym_valid cleared, bit ignored, new table used next bit.

Source files
------------

// File: rtl/hf_decoder_if.sv
// hf_decoder_if
//   Groups the two streaming handshakes of the Huffman decoder:
//   the serial bit input and the decoded symbol output.
//   Ports/signals:
//     bit_in, bit_valid   -> decoder   stream bit (code MSB first) and its valid
//     bit_ready           <- decoder   decoder takes bit_in this cycle
//     sym_out, sym_valid  <- decoder   decoded symbol index and its valid
//     sym_ready           -> decoder   downstream accepts sym_out
//   Modports:
//     master  the stream source / symbol sink (e.g. a testbench)
//     slave   the decoder
interface hf_decoder_if #(
    parameter int SW = 3
);
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic [SW-1:0] sym_out;
    logic          sym_valid;
    logic          sym_ready;

    modport master (
        output bit_in, bit_valid, sym_ready,
        input  bit_ready, sym_out, sym_valid
    );

    modport slave (
        input  bit_in, bit_valid, sym_ready,
        output bit_ready, sym_out, sym_valid
    );
endinterface

// File: rtl/hf_decoder.sv
// hf_decoder
//   Serial Huffman decoder for the 5-symbol HF code table. A packed table of
//   right-justified codes plus their lengths is loaded with tbl_load; the
//   bitstream then arrives one bit per cycle and each completed code is
//   emitted as a symbol index on a valid/ready output.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous, active-high reset
//     tbl_load    capture code_table/code_len this cycle (beats bit accept)
//     code_table  NSYM*CW packed codes, sym0 in the top field
//     code_len    NSYM*LW packed lengths, sym0 in the top field, legal 1..CW
//     bus         hf_decoder_if slave: bit_in/bit_valid/bit_ready in,
//                 sym_out/sym_valid/sym_ready out
//     err         sticky error: no code matched in CW bits or bad length
//     busy        a partial code is being held
module hf_decoder #(
    parameter int NSYM = 5,
    parameter int CW   = 4,
    parameter int LW   = 3,
    parameter int SW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tbl_load,
    input  logic [NSYM*CW-1:0] code_table,
    input  logic [NSYM*LW-1:0] code_len,
    hf_decoder_if.slave        bus,
    output logic               err,
    output logic               busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] tbl_code [NSYM];
    logic [LW-1:0] tbl_len  [NSYM];
    logic [CW-1:0] acc, acc_n, mask;
    logic [LW-1:0] cnt, cnt_n;
    logic [SW-1:0] sym_out_q, match_idx;
    logic          sym_valid_q;
    logic          accept, match, load_bad, code_full;

    // The error flag is exactly "sitting in ERR": only a table load leaves it.
    assign err           = (state == ERR);
    assign busy          = (cnt != '0);
    assign bus.bit_ready = (state == RUN) && (!sym_valid_q || bus.sym_ready);
    assign bus.sym_out   = sym_out_q;
    assign bus.sym_valid = sym_valid_q;
    assign accept        = bus.bit_valid && bus.bit_ready;

    // A length of zero or longer than the field width makes the table unusable.
    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            if ((code_len[(NSYM-1-i)*LW +: LW] == '0) ||
                (code_len[(NSYM-1-i)*LW +: LW] > LW'(CW))) begin
                load_bad = 1'b1;
            end
        end
    end

    // Candidate accumulator after taking bit_in, and the table lookup on it.
    // Only the low cnt_n bits take part in the compare. Scanning from the top
    // index down lets the lowest matching index win on a table with duplicates.
    always_comb begin
        acc_n     = {acc[CW-2:0], bus.bit_in};
        cnt_n     = cnt + LW'(1);
        code_full = (cnt_n == LW'(CW));
        for (int b = 0; b < CW; b++) begin
            mask[b] = (LW'(b) < cnt_n);
        end
        match     = 1'b0;
        match_idx = '0;
        for (int i = NSYM-1; i >= 0; i--) begin
            if ((tbl_len[i] == cnt_n) && ((tbl_code[i] & mask) == (acc_n & mask))) begin
                match     = 1'b1;
                match_idx = SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tbl_load) begin
            state_next = load_bad ? ERR : RUN;
        end else if (accept && !match && code_full) begin
            state_next = ERR;
        end
    end

    // Datapath: table capture, bit accumulation and the output register.
    // The output is released by the handshake first, so a match landing in the
    // same cycle overwrites it and keeps sym_valid high for full-rate output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSYM; i++) begin
                tbl_code[i] <= '0;
                tbl_len[i]  <= '0;
            end
            acc         <= '0;
            cnt         <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
        end else if (tbl_load) begin
            for (int i = 0; i < NSYM; i++) begin
                tbl_code[i] <= code_table[(NSYM-1-i)*CW +: CW];
                tbl_len[i]  <= code_len[(NSYM-1-i)*LW +: LW];
            end
            acc         <= '0;
            cnt         <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            if (sym_valid_q && bus.sym_ready) begin
                sym_valid_q <= 1'b0;
            end
            if (accept) begin
                if (match) begin
                    sym_out_q   <= match_idx;
                    sym_valid_q <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else if (code_full) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc_n;
                    cnt <= cnt_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_hf_decoder.sv
// tb_hf_decoder
//   Directed scenarios for load, stall, duplicate codes, bad lengths, reset
//   and load priority, followed by a randomized run where random symbols are
//   Huffman-encoded with the reference code list and must come back in order
//   with exact one-cycle latency.
module tb_hf_decoder;
    localparam int NSYM = 5;
    localparam int CW   = 4;
    localparam int LW   = 3;
    localparam int SW   = 3;

    localparam logic [NSYM*CW-1:0] TBL_T   = 20'h01267;
    localparam logic [NSYM*LW-1:0] LEN_T   = 15'h22E4;
    localparam logic [NSYM*CW-1:0] TBL_DUP = 20'h01266;
    localparam logic [NSYM*LW-1:0] LEN_BAD = 15'h2224;
    localparam logic [NSYM*CW-1:0] TBL_SWP = 20'h10267;
    localparam logic [NSYM*LW-1:0] LEN_SWP = 15'h14E4;

    logic               clk = 1'b0;
    logic               rst;
    logic               tbl_load;
    logic [NSYM*CW-1:0] code_table;
    logic [NSYM*LW-1:0] code_len;
    logic               err;
    logic               busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference code list for table T: s0=00, s1=1, s2=010, s3=0110, s4=0111
    int refCode [NSYM] = '{0, 1, 2, 6, 7};
    int refLen  [NSYM] = '{2, 1, 3, 4, 4};

    hf_decoder_if #(.SW(SW)) bus ();

    hf_decoder #(.NSYM(NSYM), .CW(CW), .LW(LW), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_load   (tbl_load),
        .code_table (code_table),
        .code_len   (code_len),
        .bus        (bus),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic bv, input logic b, input logic sr);
        bus.bit_valid = bv;
        bus.bit_in    = b;
        bus.sym_ready = sr;
    endtask

    task automatic loadTable(input logic [NSYM*CW-1:0] tbl, input logic [NSYM*LW-1:0] len);
        tbl_load   = 1'b1;
        code_table = tbl;
        code_len   = len;
        tick();
        tbl_load   = 1'b0;
    endtask

    // Hold a bit until the decoder takes it; returns just after the taking edge.
    task automatic sendBit(input logic b);
        int waitCycles = 0;
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        @(negedge clk);
        while (!bus.bit_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("bit_accept", bus.bit_ready, 1);
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    // Send one code MSB first with sym_ready held high.
    task automatic sendCode(input string tag, input int code, input int len, input int expSym);
        for (int k = len - 1; k >= 0; k--) begin
            sendBit(logic'((code >> k) & 1));
            if (k > 0) begin
                checkOutput({tag, "_busy"}, busy, 1);
                checkOutput({tag, "_novalid"}, bus.sym_valid, 0);
            end else begin
                checkOutput({tag, "_valid"}, bus.sym_valid, 1);
                checkOutput({tag, "_sym"}, bus.sym_out, expSym);
                checkOutput({tag, "_idle"}, busy, 0);
            end
        end
    endtask

    initial begin
        int   symQ [$];
        logic bitQ [$];
        logic lastQ [$];
        logic modelValid;
        int   modelSym;
        logic expReady;
        int   cyc;

        rst        = 1'b1;
        tbl_load   = 1'b0;
        code_table = '0;
        code_len   = '0;
        applyStimulus(0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_sym_out", bus.sym_out, 0);
        checkOutput("rst_sym_valid", bus.sym_valid, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        applyStimulus(1, 1, 1);
        #1;
        checkOutput("idle_bit_ready", bus.bit_ready, 0);
        tick();
        checkOutput("idle_no_sym", bus.sym_valid, 0);

        $display("[TB] test 1: basic stream");
        applyStimulus(0, 0, 1);
        loadTable(TBL_T, LEN_T);
        checkOutput("t1_err", err, 0);
        checkOutput("t1_ready", bus.bit_ready, 1);
        sendCode("t1_s1", 1, 1, 1);
        sendCode("t1_s0", 0, 2, 0);
        sendCode("t1_s2", 2, 3, 2);
        sendCode("t1_s4", 7, 4, 4);
        checkOutput("t1_err_end", err, 0);

        $display("[TB] test 2: output stall");
        applyStimulus(0, 0, 0);
        loadTable(TBL_T, LEN_T);
        applyStimulus(1, 1, 0);
        tick();
        checkOutput("t2_first_valid", bus.sym_valid, 1);
        checkOutput("t2_first_sym", bus.sym_out, 1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t2_stall_ready", bus.bit_ready, 0);
            tick();
            checkOutput("t2_stall_valid", bus.sym_valid, 1);
        end
        bus.sym_ready = 1'b1;
        #1;
        checkOutput("t2_resume_ready", bus.bit_ready, 1);
        tick();
        checkOutput("t2_second_valid", bus.sym_valid, 1);
        checkOutput("t2_second_sym", bus.sym_out, 1);
        tick();
        checkOutput("t2_third_valid", bus.sym_valid, 1);
        checkOutput("t2_third_sym", bus.sym_out, 1);
        bus.bit_valid = 1'b0;
        tick();
        checkOutput("t2_drained", bus.sym_valid, 0);

        $display("[TB] test 3: duplicate code and mismatch");
        applyStimulus(0, 0, 1);
        loadTable(TBL_DUP, LEN_T);
        sendCode("t3_dup", 6, 4, 3);
        sendBit(0);
        sendBit(1);
        sendBit(1);
        checkOutput("t3_busy", busy, 1);
        sendBit(1);
        checkOutput("t3_err", err, 1);
        checkOutput("t3_busy_clr", busy, 0);
        applyStimulus(1, 0, 1);
        #1;
        checkOutput("t3_err_ready", bus.bit_ready, 0);
        tick();
        tick();
        checkOutput("t3_err_sticky", err, 1);
        checkOutput("t3_err_ready2", bus.bit_ready, 0);
        applyStimulus(0, 0, 1);
        loadTable(TBL_T, LEN_T);
        checkOutput("t3_reload_err", err, 0);
        checkOutput("t3_reload_ready", bus.bit_ready, 1);

        $display("[TB] test 4: illegal length");
        loadTable(TBL_T, LEN_BAD);
        checkOutput("t4_err", err, 1);
        bus.bit_valid = 1'b1;
        #1;
        checkOutput("t4_ready", bus.bit_ready, 0);
        bus.bit_valid = 1'b0;
        loadTable(TBL_T, LEN_T);
        checkOutput("t4_reload_err", err, 0);
        checkOutput("t4_reload_ready", bus.bit_ready, 1);

        $display("[TB] test 5: reset mid-code");
        sendBit(0);
        sendBit(1);
        checkOutput("t5_busy", busy, 1);
        rst = 1'b1;
        bus.bit_valid = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_sym_out", bus.sym_out, 0);
        checkOutput("t5_sym_valid", bus.sym_valid, 0);
        checkOutput("t5_err", err, 0);
        checkOutput("t5_busy_clr", busy, 0);
        checkOutput("t5_ready", bus.bit_ready, 0);
        tick();
        checkOutput("t5_still_idle", bus.bit_ready, 0);
        bus.bit_valid = 1'b0;
        loadTable(TBL_T, LEN_T);
        sendCode("t5_after", 6, 4, 3);

        $display("[TB] test 6: load during pending output");
        applyStimulus(0, 0, 1);
        loadTable(TBL_T, LEN_T);
        applyStimulus(1, 1, 0);
        tick();
        checkOutput("t6_pending", bus.sym_valid, 1);
        tbl_load   = 1'b1;
        code_table = TBL_SWP;
        code_len   = LEN_SWP;
        applyStimulus(1, 1, 1);
        tick();
        tbl_load = 1'b0;
        applyStimulus(0, 0, 1);
        checkOutput("t6_valid_clr", bus.sym_valid, 0);
        checkOutput("t6_bit_ignored", busy, 0);
        checkOutput("t6_sym_hold", bus.sym_out, 1);
        sendCode("t6_new", 1, 1, 0);

        $display("[TB] random stream");
        applyStimulus(0, 0, 1);
        loadTable(TBL_T, LEN_T);
        for (int n = 0; n < 300; n++) begin
            int s = int'($urandom_range(0, NSYM - 1));
            symQ.push_back(s);
            for (int k = refLen[s] - 1; k >= 0; k--) begin
                bitQ.push_back(logic'((refCode[s] >> k) & 1));
                lastQ.push_back(k == 0);
            end
        end
        modelValid = 1'b0;
        modelSym   = 0;
        cyc        = 0;
        while ((bitQ.size() > 0 || modelValid) && cyc < 10000) begin
            bus.bit_valid = (bitQ.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.bit_in    = (bitQ.size() > 0) ? bitQ[0] : 1'b0;
            bus.sym_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checkOutput("rnd_valid", bus.sym_valid, modelValid);
            if (modelValid) begin
                checkOutput("rnd_sym", bus.sym_out, modelSym);
            end
            checkOutput("rnd_err", err, 0);
            expReady = !modelValid || bus.sym_ready;
            checkOutput("rnd_bit_ready", bus.bit_ready, expReady);
            if (modelValid && bus.sym_ready) begin
                modelValid = 1'b0;
            end
            if (bus.bit_valid && expReady) begin
                void'(bitQ.pop_front());
                if (lastQ.pop_front()) begin
                    modelValid = 1'b1;
                    modelSym   = symQ.pop_front();
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("rnd_bits_left", bitQ.size(), 0);
        checkOutput("rnd_syms_left", symQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
